// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared constants for the instruction-fetch front end.
//   ADDR_W           address/data width
//   S_IDLE..S_HOLD   2-bit fetch FSM encoding
//   NOP              value of the holding register after reset
package pc_fetch_unit_pkg;
    localparam int ADDR_W = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    localparam logic [ADDR_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_unit_hold_reg.sv
// pc_fetch_unit_hold_reg: one-entry holding register for the instruction presented to decode.
//   clk, rst_n  clock, async active-low reset
//   load_i      capture data_i/pc_i
//   data_i/o    instruction word in/held
//   pc_i/o      instruction PC in/held
module pc_fetch_unit_hold_reg
    import pc_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] data_q, pc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= NOP;
            pc_q   <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end
    assign data_o = data_q;
    assign pc_o   = pc_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register plus non-pipelined imem fetch with redirect and stale-response drop.
//   clk, rst_n                      clock, async active-low reset
//   current_addr_pc / next_addr_pc  PC out to external adder, adder result back
//   imem_req_valid/ready, imem_addr request channel (word address)
//   imem_rsp_valid, imem_rsp_data   response channel
//   inst_valid/ready, inst_data/pc  held instruction to decode
//   redirect_valid, redirect_addr   control-flow redirect from execute
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] current_addr_pc,
    input  logic [ADDR_W-1:0] next_addr_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [ADDR_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic              drop_q, drop_d, load;
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                state_d = imem_req_ready ? S_WAIT : S_REQ;
                // the request still goes out with the old address; its response must be discarded
                drop_d  = drop_q | redirect_valid;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    // a same-cycle redirect discards the response directly, so no drop is left pending
                    load    = !(drop_q || redirect_valid);
                    state_d = load ? S_HOLD : S_REQ;
                    pc_d    = load ? next_addr_pc : pc_q;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = drop_q | redirect_valid;
                end
            end
            default: state_d = (inst_ready || redirect_valid) ? S_REQ : S_HOLD;
        endcase
        if (redirect_valid) pc_d = redirect_addr;
        // latch the fetch address on every entry into REQ, using the PC as it will be next cycle
        addr_d = (state_d == S_REQ && state_q != S_REQ) ? pc_d : addr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_ADDR;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end
    pc_fetch_unit_hold_reg u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .data_i (imem_rsp_data),
        .pc_i   (addr_q),
        .data_o (inst_data),
        .pc_o   (inst_pc)
    );
    assign current_addr_pc = pc_q;
    assign imem_addr       = addr_q;
    assign imem_req_valid  = (state_q == S_REQ);
    assign inst_valid      = (state_q == S_HOLD);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a stream-level model.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] current_addr_pc, next_addr_pc, imem_addr, imem_rsp_data, inst_data, inst_pc, redirect_addr;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, inst_valid, inst_ready, redirect_valid;
    int          tests = 0, fails = 0, n_deliv = 0, lat = 1, rsp_cnt = 0;
    logic [31:0] exp_pc, req_addr, hold_d, hold_p;

    pc_fetch_unit #(.RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .current_addr_pc(current_addr_pc), .next_addr_pc(next_addr_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
    );

    always #5 clk = ~clk;
    // external next-address adder: sequential fetch
    assign next_addr_pc = current_addr_pc + 32'd1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: score the cycle that is ending, then play memory for the new cycle
    task automatic tick();
        logic hs, dlv;
        hs  = imem_req_valid && imem_req_ready;
        dlv = inst_valid && inst_ready && !redirect_valid;
        if (dlv) begin
            chk("deliv_pc", inst_pc, exp_pc);
            chk("deliv_data", inst_data, mem(exp_pc));
            exp_pc = exp_pc + 32'd1;
            n_deliv++;
        end
        if (redirect_valid) exp_pc = redirect_addr;
        if (hs) begin
            req_addr = imem_addr;
            rsp_cnt  = lat;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem(req_addr);
            end
        end
    endtask

    // what: 0 = REQ at address a, 1 = any REQ, 2 = instruction held
    task automatic wait_for(input int what, input logic [31:0] a, input string tag);
        int n = 0;
        while (!(what == 0 ? (imem_req_valid && imem_addr == a) : what == 1 ? imem_req_valid : inst_valid) && n < 100) begin
            tick();
            n++;
        end
        tests++;
        assert (n < 100) else begin
            fails++;
            $error("FAIL %s: no event within %0d cycles, required within 100", tag, n);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pc"}, current_addr_pc, 32'h0);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_inst_data"}, inst_data, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, base;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        inst_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = 32'h0; exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        // sequential fetch from RESET_ADDR
        rst_n = 1'b1;
        tick();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("first_req_addr", imem_addr, 32'h0);
        tick();
        chk("wait_no_inst", {31'b0, inst_valid}, 32'h0);
        chk("wait_no_req", {31'b0, imem_req_valid}, 32'h0);
        tick();
        chk("hold_valid_n2", {31'b0, inst_valid}, 32'h1);
        chk("hold_pc0", inst_pc, 32'h0);
        n = 0;
        while (n_deliv < 3 && n < 50) begin tick(); n++; end
        chk("three_delivered", n_deliv, 3);
        // request stalled by imem_req_ready
        wait_for(0, 32'd5, "wait_req5");
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("stall_addr", imem_addr, 32'd5);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("stall_accepted", {31'b0, imem_req_valid}, 32'h0);
        // decode back-pressure
        inst_ready = 1'b0;
        wait_for(2, 32'h0, "wait_hold");
        hold_d = inst_data; hold_p = inst_pc;
        chk("hold_pc5", hold_p, 32'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'b0, inst_valid}, 32'h1);
            chk("bp_data", inst_data, hold_d);
            chk("bp_pc", inst_pc, hold_p);
            chk("bp_no_req", {31'b0, imem_req_valid}, 32'h0);
        end
        inst_ready = 1'b1;
        // redirect while waiting for addr 7
        wait_for(0, 32'd7, "wait_req7");
        lat = 2;
        tick();
        chk("w7_waiting", {31'b0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b1; redirect_addr = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_pc", current_addr_pc, 32'h40);
        tick();
        chk("redir_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("redir_req_addr", imem_addr, 32'h40);
        lat = 1;
        wait_for(2, 32'h0, "wait_hold40");
        chk("redir_inst_pc", inst_pc, 32'h40);
        chk("redir_inst_data", inst_data, mem(32'h40));
        // redirect coinciding with the response
        wait_for(1, 32'h0, "wait_req41");
        tick();
        redirect_valid = 1'b1; redirect_addr = 32'h80;
        tick();
        redirect_valid = 1'b0;
        chk("same_no_inst", {31'b0, inst_valid}, 32'h0);
        chk("same_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("same_req_addr", imem_addr, 32'h80);
        // redirect in HOLD with decode ready
        wait_for(2, 32'h0, "wait_hold80");
        chk("hold80_pc", inst_pc, 32'h80);
        redirect_valid = 1'b1; redirect_addr = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("hredir_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("hredir_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("hredir_req_addr", imem_addr, 32'h100);
        wait_for(2, 32'h0, "wait_hold100");
        chk("hold100_pc", inst_pc, 32'h100);
        // asynchronous reset during WAIT, stale response arrives afterwards
        wait_for(1, 32'h0, "wait_req101");
        lat = 3;
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_pc = 32'h0;
        chk_reset_outs("async_reset");
        lat = 1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("refetch_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("refetch_addr", imem_addr, 32'h0);
        wait_for(2, 32'h0, "wait_refetch");
        chk("refetch_inst_pc", inst_pc, 32'h0);
        chk("refetch_inst_data", inst_data, mem(32'h0));
        // randomized traffic, redirects and back-pressure, including PC wrap
        base = n_deliv;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = $urandom_range(0, 3) != 0;
            inst_ready     = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            lat            = $urandom_range(1, 3);
            tick();
            tests++;
            assert (!(imem_req_valid && inst_valid)) else begin
                fails++;
                $error("FAIL overlap: observed req_valid=%b inst_valid=%b expected not both", imem_req_valid, inst_valid);
            end
        end
        redirect_valid = 1'b0;
        tests++;
        assert (n_deliv - base >= 40) else begin
            fails++;
            $error("FAIL random_progress: observed %0d deliveries expected >= 40", n_deliv - base);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
